// File: rtl/scrambler_pkg.sv
// Shared types and constants for the frame-aware byte scrambler.
package scrambler_pkg;

  // Frame position: header bytes pass through, payload bytes are scrambled.
  typedef enum logic {
    ST_HDR = 1'b0,
    ST_PLD = 1'b1
  } state_e;

  localparam int lp_STATE_W = 16;

  localparam logic [lp_STATE_W-1:0] lp_DEF_POLYNOMIAL = 16'h801C;
  localparam logic [lp_STATE_W-1:0] lp_DEF_RESET_SEED = 16'hFFFF;

endpackage

// File: rtl/scrambler_lfsr_step8.sv
// Combinational 8-step LFSR unroll: one keystream byte per call.
// Kept standalone so the matching descrambler can share it.
module lfsr_step8
  import scrambler_pkg::*;
(
  input  logic [lp_STATE_W-1:0] state,
  input  logic [lp_STATE_W-1:0] poly,
  output logic [7:0]            key,
  output logic [lp_STATE_W-1:0] state_next
);

  // st[k] is the state before step k; st[8] is the state after a full byte.
  logic [8:0][lp_STATE_W-1:0] st;

  assign st[0] = state;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_step
      logic fb;
      // Feedback bit doubles as key bit gi; step 0 drives the key LSB.
      assign fb         = ^(st[gi] & poly);
      assign key[gi]    = fb;
      assign st[gi + 1] = {fb, st[gi][lp_STATE_W-1:1]};
    end
  endgenerate

  assign state_next = st[8];

endmodule

// File: rtl/scrambler_ctrl.sv
// Frame-aware byte scrambler: header passthrough, payload XOR with an LFSR
// keystream that only advances on accepted payload bytes, reseeded per frame.
module scrambler_ctrl
  import scrambler_pkg::*;
#(
  parameter int                    p_HEADER_BYTES = 2,
  parameter logic [lp_STATE_W-1:0] p_POLYNOMIAL   = lp_DEF_POLYNOMIAL,
  parameter logic [lp_STATE_W-1:0] p_RESET_SEED   = lp_DEF_RESET_SEED
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  input  logic                  i_S_VALID,
  output logic                  o_S_READY,
  input  logic [7:0]            i_S_DATA,
  input  logic                  i_S_LAST,
  output logic                  o_M_VALID,
  input  logic                  i_M_READY,
  output logic [7:0]            o_M_DATA,
  output logic                  o_M_LAST,
  input  logic [lp_STATE_W-1:0] i_SEED,
  input  logic                  i_SEED_LOAD,
  input  logic                  i_BYPASS,
  output logic                  o_SEED_ERR,
  output logic [15:0]           o_FRAME_CNT
);

  // With no header the frame starts directly in payload.
  localparam state_e     lp_START    = (p_HEADER_BYTES == 0) ? ST_PLD : ST_HDR;
  localparam logic [7:0] lp_HDR_LAST = (p_HEADER_BYTES == 0) ? 8'd0 : 8'(p_HEADER_BYTES - 1);

  state_e                state_reg, state_next;
  logic [7:0]            hdr_cnt_reg, hdr_cnt_next;
  logic [lp_STATE_W-1:0] lfsr_reg;
  logic [lp_STATE_W-1:0] seed_reg;
  logic                  first_reg;
  logic                  bypass_reg;
  logic                  m_valid_reg;
  logic [7:0]            m_data_reg;
  logic                  m_last_reg;
  logic                  seed_err_reg;
  logic [15:0]           frame_cnt_reg;

  logic                  accept;
  logic                  seed_ok;
  logic [lp_STATE_W-1:0] seed_eff;
  logic                  bypass_eff;
  logic                  scramble_en;
  logic [7:0]            key;
  logic [lp_STATE_W-1:0] lfsr_next;

  lfsr_step8 u_lfsr_step8 (
    .state      (lfsr_reg),
    .poly       (p_POLYNOMIAL),
    .key        (key),
    .state_next (lfsr_next)
  );

  // The output stage can take a new byte when empty or draining this cycle.
  assign o_S_READY = ~m_valid_reg | i_M_READY;
  assign accept    = i_S_VALID & o_S_READY;

  // A good load arriving with LAST must already seed the next frame.
  assign seed_ok  = i_SEED_LOAD & (i_SEED != '0);
  assign seed_eff = seed_ok ? i_SEED : seed_reg;

  // Bypass is sampled live on the first byte, then held for the frame.
  assign bypass_eff  = first_reg ? i_BYPASS : bypass_reg;
  assign scramble_en = (state_reg == ST_PLD) & ~bypass_eff;

  // Next-state: header counting, move to payload, restart on LAST.
  always_comb begin
    state_next   = state_reg;
    hdr_cnt_next = hdr_cnt_reg;
    if (accept) begin
      if (i_S_LAST) begin
        state_next   = lp_START;
        hdr_cnt_next = 8'd0;
      end else if (state_reg == ST_HDR) begin
        hdr_cnt_next = hdr_cnt_reg + 8'd1;
        if (hdr_cnt_reg == lp_HDR_LAST) begin
          state_next = ST_PLD;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_reg   <= lp_START;
      hdr_cnt_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      hdr_cnt_reg <= hdr_cnt_next;
    end
  end

  // Keystream state, seed register and per-frame bypass latch.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      lfsr_reg   <= p_RESET_SEED;
      seed_reg   <= p_RESET_SEED;
      first_reg  <= 1'b1;
      bypass_reg <= 1'b0;
    end else begin
      if (seed_ok) begin
        seed_reg <= i_SEED;
      end
      if (accept) begin
        if (i_S_LAST) begin
          lfsr_reg  <= seed_eff;
          first_reg <= 1'b1;
        end else begin
          first_reg  <= 1'b0;
          bypass_reg <= bypass_eff;
          if (scramble_en) begin
            lfsr_reg <= lfsr_next;
          end
        end
      end
    end
  end

  // Single output register stage; holds while downstream stalls.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= 8'd0;
      m_last_reg  <= 1'b0;
    end else if (accept) begin
      m_valid_reg <= 1'b1;
      m_data_reg  <= scramble_en ? (i_S_DATA ^ key) : i_S_DATA;
      m_last_reg  <= i_S_LAST;
    end else if (i_M_READY) begin
      m_valid_reg <= 1'b0;
    end
  end

  // Status: sticky zero-seed error and completed-frame counter.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      seed_err_reg  <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      if (i_SEED_LOAD && (i_SEED == '0)) begin
        seed_err_reg <= 1'b1;
      end
      if (accept && i_S_LAST) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign o_M_VALID   = m_valid_reg;
  assign o_M_DATA    = m_data_reg;
  assign o_M_LAST    = m_last_reg;
  assign o_SEED_ERR  = seed_err_reg;
  assign o_FRAME_CNT = frame_cnt_reg;

endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed bench for scrambler_ctrl with a byte-level scoreboard model.
module tb_scrambler_ctrl;

  logic        i_CLK = 1'b0;
  logic        i_RESET = 1'b1;
  logic        i_S_VALID = 1'b0;
  logic        o_S_READY;
  logic [7:0]  i_S_DATA = 8'd0;
  logic        i_S_LAST = 1'b0;
  logic        o_M_VALID;
  logic        i_M_READY = 1'b1;
  logic [7:0]  o_M_DATA;
  logic        o_M_LAST;
  logic [15:0] i_SEED = 16'd0;
  logic        i_SEED_LOAD = 1'b0;
  logic        i_BYPASS = 1'b0;
  logic        o_SEED_ERR;
  logic [15:0] o_FRAME_CNT;

  scrambler_ctrl dut (
    .i_CLK       (i_CLK),
    .i_RESET     (i_RESET),
    .i_S_VALID   (i_S_VALID),
    .o_S_READY   (o_S_READY),
    .i_S_DATA    (i_S_DATA),
    .i_S_LAST    (i_S_LAST),
    .o_M_VALID   (o_M_VALID),
    .i_M_READY   (i_M_READY),
    .o_M_DATA    (o_M_DATA),
    .o_M_LAST    (o_M_LAST),
    .i_SEED      (i_SEED),
    .i_SEED_LOAD (i_SEED_LOAD),
    .i_BYPASS    (i_BYPASS),
    .o_SEED_ERR  (o_SEED_ERR),
    .o_FRAME_CNT (o_FRAME_CNT)
  );

  always #5 i_CLK = ~i_CLK;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: expected {last, data} per accepted byte; captured data bytes.
  logic [8:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] saved[4];

  // Reference model state.
  logic [15:0] m_S, m_seed, m_fc;
  logic        m_err, m_pld, m_first, m_byp;
  int          m_hcnt;
  logic        stall_mode = 1'b0;
  logic        last_acc;

  function automatic logic [23:0] mdl_step8(input logic [15:0] s);
    logic [7:0] k;
    logic       b;
    k = 8'd0;
    for (int i = 0; i < 8; i++) begin
      b    = ^(s & 16'h801C);
      k[i] = b;
      s    = {b, s[15:1]};
    end
    return {k, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_S = 16'hFFFF; m_seed = 16'hFFFF; m_fc = 16'd0; m_err = 1'b0;
    m_pld = 1'b0; m_hcnt = 0; m_first = 1'b1; m_byp = 1'b0;
  endtask

  task automatic model_accept();
    logic        byp;
    logic [7:0]  out;
    logic [15:0] seed_eff;
    logic [23:0] r;
    byp = m_first ? i_BYPASS : m_byp;
    out = i_S_DATA;
    if (m_pld && !byp) begin
      r   = mdl_step8(m_S);
      out = i_S_DATA ^ r[23:16];
      m_S = r[15:0];
    end
    exp_q.push_back({i_S_LAST, out});
    seed_eff = (i_SEED_LOAD && i_SEED != 16'd0) ? i_SEED : m_seed;
    if (i_S_LAST) begin
      m_S = seed_eff; m_pld = 1'b0; m_hcnt = 0; m_fc = m_fc + 16'd1; m_first = 1'b1;
    end else begin
      m_first = 1'b0;
      m_byp   = byp;
      if (!m_pld) begin
        if (m_hcnt == 1) m_pld = 1'b1;
        m_hcnt++;
      end
    end
  endtask

  // One clock: check/observe at negedge, model the edge, drive after posedge.
  task automatic tick();
    logic       acc;
    logic [8:0] e;
    acc = 1'b0;
    @(negedge i_CLK);
    if (i_RESET) begin
      exp_q.delete();
    end else begin
      chk("frame_cnt", 32'(o_FRAME_CNT), 32'(m_fc));
      chk("seed_err", 32'(o_SEED_ERR), 32'(m_err));
      if (o_M_VALID && i_M_READY) begin
        $display("[%0t] out data=%02h last=%0b", $time, o_M_DATA, o_M_LAST);
        got_q.push_back(o_M_DATA);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(o_M_VALID), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", 32'(o_M_DATA), 32'(e[7:0]));
          chk("m_last", 32'(o_M_LAST), 32'(e[8]));
        end
      end
      acc = i_S_VALID && o_S_READY;
      if (acc) model_accept();
      if (i_SEED_LOAD) begin
        if (i_SEED != 16'd0) m_seed = i_SEED;
        else m_err = 1'b1;
      end
    end
    @(posedge i_CLK);
    #1;
    if (i_RESET) model_reset();
    i_SEED_LOAD = 1'b0;
    if (stall_mode) i_M_READY = ~i_M_READY;
    last_acc = acc;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic byp);
    int n;
    i_S_VALID = 1'b1; i_S_DATA = d; i_S_LAST = l; i_BYPASS = byp;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 200) begin
      tick();
      n++;
    end
    if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
    i_BYPASS = 1'b0;
  endtask

  task automatic drain();
    i_S_VALID = 1'b0; i_S_LAST = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic zero_frame();
    for (int i = 0; i < 4; i++) send_byte(8'h00, (i == 3), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bd[6];
    model_reset();
    // Reset and reset values
    i_RESET = 1'b1; tick(); tick(); i_RESET = 1'b0;
    chk("rst_m_valid", 32'(o_M_VALID), 32'd0);
    chk("rst_m_data", 32'(o_M_DATA), 32'd0);
    chk("rst_m_last", 32'(o_M_LAST), 32'd0);
    chk("rst_frame_cnt", 32'(o_FRAME_CNT), 32'd0);
    chk("rst_seed_err", 32'(o_SEED_ERR), 32'd0);

    // Frame of 4 zero bytes, no backpressure
    got_q.delete(); zero_frame(); drain();
    chk("nostall_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("hdr0", 32'(got_q[0]), 32'h00);
      chk("hdr1", 32'(got_q[1]), 32'h00);
      chk("pld0", 32'(got_q[2]), 32'hAA);
      for (int i = 0; i < 4; i++) saved[i] = got_q[i];
    end
    chk("frame_cnt_1", 32'(o_FRAME_CNT), 32'd1);

    // Same frame with ready toggling 1010...
    got_q.delete(); stall_mode = 1'b1; i_M_READY = 1'b1;
    zero_frame(); drain();
    stall_mode = 1'b0; i_M_READY = 1'b1;
    chk("stall_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("stall_byte", 32'(got_q[i]), 32'(saved[i]));

    // Back-to-back frames reseed at the boundary
    got_q.delete(); zero_frame(); zero_frame(); drain();
    chk("b2b_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) chk("b2b_pld0_f2", 32'(got_q[6]), 32'hAA);

    // Seed load mid-payload: current frame keeps old keystream
    got_q.delete();
    for (int i = 0; i < 6; i++) bd[i] = 8'(8'h11 * (i + 1));
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin i_SEED = 16'h1234; i_SEED_LOAD = 1'b1; end
      send_byte(bd[i], (i == 5), 1'b0);
    end
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), (i == 5), 1'b0);
    drain();
    chk("seed_frames_count", 32'(got_q.size()), 32'd12);

    // Restore seed, then a zero seed load: error set, seed unchanged
    i_SEED = 16'hFFFF; i_SEED_LOAD = 1'b1; tick();
    i_SEED = 16'h0000; i_SEED_LOAD = 1'b1; tick(); tick();
    chk("seed_err_set", 32'(o_SEED_ERR), 32'd1);
    got_q.delete(); zero_frame(); zero_frame(); drain();
    if (got_q.size() == 8) chk("zero_seed_pld0", 32'(got_q[6]), 32'hAA);
    else chk("zero_seed_count", 32'(got_q.size()), 32'd8);

    // Bypass latched on the first byte only
    got_q.delete();
    for (int i = 0; i < 6; i++) bd[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) send_byte(bd[i], (i == 5), (i == 0));
    drain();
    if (got_q.size() == 6) for (int i = 2; i < 6; i++) chk("bypass_pld", 32'(got_q[i]), 32'(bd[i]));
    else chk("bypass_count", 32'(got_q.size()), 32'd6);

    // LAST on header byte 0, then a normal frame
    got_q.delete();
    send_byte(8'h5A, 1'b1, 1'b0); zero_frame(); drain();
    if (got_q.size() == 5) begin
      chk("short_frame", 32'(got_q[0]), 32'h5A);
      chk("after_short_hdr", 32'(got_q[2]), 32'h00);
      chk("after_short_pld0", 32'(got_q[3]), 32'hAA);
    end else chk("short_count", 32'(got_q.size()), 32'd5);

    // Reset mid-frame with a held output byte
    for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b0, 1'b0);
    i_S_VALID = 1'b0; i_M_READY = 1'b0; tick();
    i_RESET = 1'b1; tick(); i_RESET = 1'b0; i_M_READY = 1'b1;
    chk("midrst_m_valid", 32'(o_M_VALID), 32'd0);
    chk("midrst_frame_cnt", 32'(o_FRAME_CNT), 32'd0);
    got_q.delete(); zero_frame(); drain();
    if (got_q.size() == 4) begin
      chk("midrst_hdr0", 32'(got_q[0]), 32'h00);
      chk("midrst_pld0", 32'(got_q[2]), 32'hAA);
    end else chk("midrst_count", 32'(got_q.size()), 32'd4);
    chk("midrst_frame_cnt_1", 32'(o_FRAME_CNT), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
